di_read_fifo: RTL and testbench

DI_READ_FIFO -- requirements
Module: di_read_fifo

---
 rtl/di_pkg.sv | 37 +++
 rtl/di_sdp_ram.sv | 24 ++
 rtl/di_read_fifo.sv | 166 ++++++++++++++++
 tb/tb_di_read_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/di_pkg.sv
// rtl/di_pkg.sv - shared register map and status bit positions for the device-interface read FIFO
package di_pkg;

   // Register offsets within the endpoint
   localparam logic [15:0] DI_REG_DATA   = 16'd0;
   localparam logic [15:0] DI_REG_COUNT  = 16'd1;
   localparam logic [15:0] DI_REG_STATUS = 16'd2;

   // STATUS bit positions
   localparam int STAT_OVERFLOW_BIT  = 0;
   localparam int STAT_UNDERFLOW_BIT = 1;

   typedef enum logic [1:0] {
      RSEL_DATA,
      RSEL_COUNT,
      RSEL_STATUS,
      RSEL_NONE
   } di_reg_sel_e;

   function automatic di_reg_sel_e di_decode_reg(input logic [15:0] addr);
      case (addr)
         DI_REG_DATA:   return RSEL_DATA;
         DI_REG_COUNT:  return RSEL_COUNT;
         DI_REG_STATUS: return RSEL_STATUS;
         default:       return RSEL_NONE;
      endcase
   endfunction

   function automatic logic [15:0] di_status_word(input logic ovf, input logic udf);
      logic [15:0] w;
      w = '0;
      w[STAT_OVERFLOW_BIT]  = ovf;
      w[STAT_UNDERFLOW_BIT] = udf;
      return w;
   endfunction

endpackage

// File: rtl/di_sdp_ram.sv
// rtl/di_sdp_ram.sv - simple dual-port RAM, one write port and one synchronous read port
module di_sdp_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

   // Write port plus registered read; reading the address being written returns the old word
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/di_read_fifo.sv
// rtl/di_read_fifo.sv - first-word-fall-through read FIFO exposed as a device-interface endpoint
module di_read_fifo
   import di_pkg::*;
#(
   parameter logic [15:0] EP_ADDR    = 16'h0002,
   parameter int          DEPTH_LOG2 = 9
) (
   input  logic        if_clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   output logic        full,
   input  logic [15:0] diEpAddr,
   input  logic [15:0] diRegAddr,
   input  logic [15:0] diRegDataIn,
   input  logic        diWrite,
   input  logic        diRead,
   input  logic        diReset,
   output logic [15:0] diRegDataOut,
   output logic        rd_ready,
   output logic        wr_ready
);

   localparam int PTR_W = DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] DEPTH_WORDS = CNT_W'(2**DEPTH_LOG2);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             r_underflow;
   logic [15:0]      r_head;
   logic             r_head_bypass;

   logic             w_sel;
   di_reg_sel_e      w_reg;
   logic             w_empty;
   logic             w_full;
   logic             w_flush;
   logic             w_pop_req;
   logic             w_pop;
   logic             w_push;
   logic             w_ovf_evt;
   logic             w_udf_evt;
   logic             w_status_wr;
   logic             w_clr_ovf;
   logic             w_clr_udf;
   logic [PTR_W-1:0] w_rd_addr;
   logic [CNT_W-1:0] w_count_nxt;
   logic [15:0]      w_ram_q;
   logic [15:0]      w_head;
   logic             w_unused_din;

   assign w_sel     = (diEpAddr == EP_ADDR);
   assign w_reg     = di_decode_reg(diRegAddr);
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_WORDS);
   assign w_flush   = w_sel && diReset;
   assign w_pop_req = w_sel && diRead && (w_reg == RSEL_DATA);

   // Flush overrides everything on the data path; a push alongside a flush is simply dropped
   assign w_pop     = w_pop_req && !w_empty && !w_flush;
   assign w_push    = wr_en && !w_flush && (!w_full || w_pop);
   assign w_ovf_evt = wr_en && w_full && !w_pop && !w_flush;
   assign w_udf_evt = w_pop_req && w_empty && !w_flush;

   assign w_status_wr  = w_sel && diWrite && (w_reg == RSEL_STATUS);
   assign w_clr_ovf    = w_status_wr && diRegDataIn[STAT_OVERFLOW_BIT];
   assign w_clr_udf    = w_status_wr && diRegDataIn[STAT_UNDERFLOW_BIT];
   assign w_unused_din = ^diRegDataIn;

   // The RAM is always reading the word that will be the head next cycle, so pops sustain one per cycle
   assign w_rd_addr = w_flush ? '0 : (w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr);

   di_sdp_ram #(
      .ADDR_W (PTR_W),
      .DATA_W (16)
   ) u_ram (
      .i_clk   (if_clock),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (wr_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   // A word written to the slot being read this cycle comes from the prefetch register instead
   assign w_head = r_head_bypass ? r_head : w_ram_q;

   // Next fill level from push/pop/flush
   always_comb begin
      w_count_nxt = r_count;
      if (w_flush) begin
         w_count_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   // Pointers, fill level and the head prefetch register
   always_ff @(posedge if_clock) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_head        <= '0;
         r_head_bypass <= 1'b0;
      end else begin
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
         end
         r_count       <= w_count_nxt;
         r_head_bypass <= w_push && (r_wr_ptr == w_rd_addr);
         if (w_push && (r_wr_ptr == w_rd_addr)) begin
            r_head <= wr_data;
         end
      end
   end

   // Sticky error flags; a new event in the same cycle as a clear keeps the flag set
   always_ff @(posedge if_clock) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= (r_overflow  && !w_clr_ovf) || w_ovf_evt;
         r_underflow <= (r_underflow && !w_clr_udf) || w_udf_evt;
      end
   end

   assign full = w_full;

   // Register read mux and handshake outputs
   always_comb begin
      diRegDataOut = '0;
      rd_ready     = 1'b0;
      wr_ready     = 1'b0;
      if (w_sel) begin
         wr_ready = 1'b1;
         rd_ready = 1'b1;
         case (w_reg)
            RSEL_DATA: begin
               rd_ready = !w_empty;
               if (!w_empty) begin
                  diRegDataOut = w_head;
               end
            end
            RSEL_COUNT:  diRegDataOut = 16'(r_count);
            RSEL_STATUS: diRegDataOut = di_status_word(r_overflow, r_underflow);
            default:     diRegDataOut = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_di_read_fifo.sv
// tb/tb_di_read_fifo.sv - self-checking bench for di_read_fifo with a queue-based reference model
module tb_di_read_fifo;

   localparam logic [15:0] EP    = 16'h0002;
   localparam int          DL2   = 2;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        full;
   logic [15:0] diEpAddr;
   logic [15:0] diRegAddr;
   logic [15:0] diRegDataIn;
   logic        diWrite;
   logic        diRead;
   logic        diReset;
   logic [15:0] diRegDataOut;
   logic        rd_ready;
   logic        wr_ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   di_read_fifo #(
      .EP_ADDR    (EP),
      .DEPTH_LOG2 (DL2)
   ) dut (
      .if_clock     (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .diEpAddr     (diEpAddr),
      .diRegAddr    (diRegAddr),
      .diRegDataIn  (diRegDataIn),
      .diWrite      (diWrite),
      .diRead       (diRead),
      .diReset      (diReset),
      .diRegDataOut (diRegDataOut),
      .rd_ready     (rd_ready),
      .wr_ready     (wr_ready)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word queue plus two sticky flags
   logic [15:0] m_q[$];
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;
   bit          m_live = 1'b0;

   always @(posedge clk) begin
      bit         msel, mflush, mpoprq, mpop, mpush, mfull, movf_ev, mudf_ev;
      logic [1:0] mclr;
      m_live = 1'b1;
      if (reset) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         msel    = (diEpAddr == EP);
         mflush  = msel && diReset;
         mpoprq  = msel && diRead && (diRegAddr == 16'd0);
         mclr    = (msel && diWrite && diRegAddr == 16'd2) ? diRegDataIn[1:0] : 2'b00;
         mfull   = (m_q.size() == DEPTH);
         movf_ev = 1'b0;
         mudf_ev = 1'b0;
         if (mflush) begin
            m_q.delete();
         end else begin
            mpop    = mpoprq && (m_q.size() > 0);
            mudf_ev = mpoprq && (m_q.size() == 0);
            mpush   = wr_en && (!mfull || mpop);
            movf_ev = wr_en && mfull && !mpop;
            if (mpop) void'(m_q.pop_front());
            if (mpush) m_q.push_back(wr_data);
         end
         m_ovf = (m_ovf && !mclr[0]) || movf_ev;
         m_udf = (m_udf && !mclr[1]) || mudf_ev;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      logic [15:0] e_data;
      logic        e_rd, e_wr;
      if (m_live) begin
         e_data = '0;
         e_rd   = 1'b0;
         e_wr   = 1'b0;
         if (diEpAddr == EP) begin
            e_wr = 1'b1;
            e_rd = 1'b1;
            case (diRegAddr)
               16'd0: begin
                  e_rd = (m_q.size() != 0);
                  if (m_q.size() != 0) e_data = m_q[0];
               end
               16'd1:   e_data = 16'(m_q.size());
               16'd2:   e_data = {14'd0, m_udf, m_ovf};
               default: e_data = '0;
            endcase
         end
         chk("cyc_data", diRegDataOut, e_data);
         chk("cyc_rd_ready", 16'(rd_ready), 16'(e_rd));
         chk("cyc_wr_ready", 16'(wr_ready), 16'(e_wr));
         chk("cyc_full", 16'(full), 16'(m_q.size() == DEPTH));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sel(input logic [15:0] addr);
      diEpAddr  = EP;
      diRegAddr = addr;
   endtask

   task automatic push_words(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = base + 16'(i);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic write_status(input logic [15:0] val);
      sel(16'd2);
      diWrite     = 1'b1;
      diRegDataIn = val;
      tick();
      diWrite     = 1'b0;
      diRegDataIn = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_data = '0; diEpAddr = '0; diRegAddr = '0;
      diRegDataIn = '0; diWrite = 1'b0; diRead = 1'b0; diReset = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      sel(16'd0);
      #1 chk("rst_full", 16'(full), 16'd0);
      chk("rst_rd_ready", 16'(rd_ready), 16'd0);
      chk("rst_data", diRegDataOut, 16'd0);

      // Four pushes then four back-to-back pops
      diEpAddr = 16'd0;
      tick();
      push_words(16'hA001, 4);
      #1 chk("full_after_4", 16'(full), 16'd1);
      sel(16'd0);
      diRead = 1'b1;
      #1 chk("burst0", diRegDataOut, 16'hA001);
      tick();
      #1 chk("burst1", diRegDataOut, 16'hA002);
      tick();
      #1 chk("burst2", diRegDataOut, 16'hA003);
      tick();
      #1 chk("burst3", diRegDataOut, 16'hA004);
      tick();
      diRead = 1'b0;
      #1 chk("burst_empty_rd_ready", 16'(rd_ready), 16'd0);

      // Overflow on a fifth push into a 4-deep FIFO
      diEpAddr = 16'd0;
      push_words(16'hB001, 5);
      #1 chk("ovf_full", 16'(full), 16'd1);
      sel(16'd1);
      #1 chk("ovf_count", diRegDataOut, 16'd4);
      sel(16'd2);
      #1 chk("ovf_status", diRegDataOut, 16'h0001);
      write_status(16'h0001);
      #1 chk("ovf_cleared", diRegDataOut, 16'h0000);

      // Push and pop together while full
      sel(16'd0);
      diRead  = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'hC0FE;
      tick();
      diRead = 1'b0;
      wr_en  = 1'b0;
      sel(16'd1);
      #1 chk("pp_count", diRegDataOut, 16'd4);
      sel(16'd2);
      #1 chk("pp_status", diRegDataOut, 16'h0000);
      sel(16'd0);
      diRead = 1'b1;
      tick();
      tick();
      tick();
      #1 chk("pp_last", diRegDataOut, 16'hC0FE);
      tick();
      diRead = 1'b0;

      // Underflow on an empty pop, then clear it
      sel(16'd0);
      diRead = 1'b1;
      tick();
      diRead = 1'b0;
      sel(16'd2);
      #1 chk("udf_status", diRegDataOut, 16'h0002);
      write_status(16'h0002);
      #1 chk("udf_cleared", diRegDataOut, 16'h0000);

      // Empty push and pop together: push wins, underflow set
      sel(16'd0);
      diRead  = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'hD001;
      tick();
      diRead = 1'b0;
      wr_en  = 1'b0;
      #1 chk("emp_pp_head", diRegDataOut, 16'hD001);
      sel(16'd2);
      #1 chk("emp_pp_status", diRegDataOut, 16'h0002);
      write_status(16'h0003);

      // Clear and overflow in the same cycle: flag stays set
      push_words(16'hD002, 3);
      sel(16'd2);
      diWrite     = 1'b1;
      diRegDataIn = 16'h0001;
      wr_en       = 1'b1;
      wr_data     = 16'hDEAD;
      tick();
      diWrite = 1'b0;
      wr_en   = 1'b0;
      #1 chk("set_wins", diRegDataOut, 16'h0001);
      write_status(16'h0001);
      sel(16'd0);
      diRead = 1'b1;
      repeat (4) tick();
      diRead = 1'b0;

      // Flush with a same-cycle push, then an unselected endpoint
      diEpAddr = 16'd0;
      push_words(16'hE001, 3);
      sel(16'd1);
      diReset = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'hE004;
      tick();
      diReset = 1'b0;
      wr_en   = 1'b0;
      #1 chk("flush_count", diRegDataOut, 16'd0);
      sel(16'd0);
      #1 chk("flush_rd_ready", 16'(rd_ready), 16'd0);
      sel(16'd2);
      #1 chk("flush_status", diRegDataOut, 16'd0);
      diEpAddr = 16'd0;
      push_words(16'hF001, 2);
      diEpAddr  = 16'd3;
      diRegAddr = 16'd0;
      #1 chk("unsel_data", diRegDataOut, 16'd0);
      chk("unsel_rd_ready", 16'(rd_ready), 16'd0);
      chk("unsel_wr_ready", 16'(wr_ready), 16'd0);
      diRegAddr = 16'd1;
      #1 chk("unsel_count", diRegDataOut, 16'd0);
      tick();

      // Mixed traffic that wraps the pointers several times
      for (int i = 0; i < 60; i++) begin
         sel((i % 7 == 6) ? 16'd1 : ((i % 11 == 10) ? 16'd5 : 16'd0));
         wr_en   = (i % 3) != 2;
         wr_data = 16'h1000 + 16'(i);
         diRead  = (i % 4) >= 2;
         tick();
      end
      wr_en  = 1'b0;
      diRead = 1'b0;
      write_status(16'h0003);
      sel(16'd0);
      diRead = 1'b1;
      repeat (5) tick();
      diRead = 1'b0;

      // Reset in the middle of a burst discards everything
      diEpAddr = 16'd0;
      push_words(16'h5501, 3);
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'h5504;
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      sel(16'd0);
      #1 chk("midrst_rd_ready", 16'(rd_ready), 16'd0);
      sel(16'd1);
      #1 chk("midrst_count", diRegDataOut, 16'd0);
      wr_en   = 1'b1;
      wr_data = 16'h7777;
      tick();
      wr_en = 1'b0;
      tick();
      sel(16'd0);
      #1 chk("midrst_new_head", diRegDataOut, 16'h7777);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
